// File: rtl/mips_pkg.sv
// Shared types and command codes for the byte-stream boot loader.
package mips_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_RUN
    } loader_state_t;

    localparam logic [7:0] CMD_WR_IMEM = 8'h01;
    localparam logic [7:0] CMD_WR_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN     = 8'h03;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready byte stream feeding the boot loader.
interface program_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes IMEM/DMEM bytes in arrival
// order and releases the processor on a RUN command.
module program_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    program_loader_if.slave   bus,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    loader_state_t     state;
    logic              to_imem;
    logic [7:0]        addr_h;
    logic [ADDR_W-1:0] ptr;
    logic [15:0]       len;
    logic              accept;
    logic              in_range;
    logic [7:0]        d;

    assign d            = bus.in_data;
    assign bus.in_ready = (state != S_RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = !(state == S_CMD || state == S_RUN);

    // Compared at 32 bits so a depth of 2^ADDR_W is not truncated.
    always_comb begin
        in_range = 1'b0;
        if (to_imem)
            in_range = 32'(ptr) < IMEM_DEPTH;
        else
            in_range = 32'(ptr) < DMEM_DEPTH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CMD;
            to_imem   <= 1'b0;
            addr_h    <= 8'h00;
            ptr       <= '0;
            len       <= 16'h0000;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            cpu_run   <= 1'b0;
            err       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            if (accept) begin
                unique case (state)
                    S_CMD: begin
                        unique case (1'b1)
                            (d == CMD_WR_IMEM),
                            (d == CMD_WR_DMEM): begin
                                to_imem <= (d == CMD_WR_IMEM);
                                state   <= S_ADDR_H;
                            end
                            (d == CMD_RUN): begin
                                cpu_run <= 1'b1;
                                state   <= S_RUN;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                    S_ADDR_H: begin
                        addr_h <= d;
                        state  <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        ptr   <= ADDR_W'({addr_h, d});
                        state <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        len   <= {d, 8'h00};
                        state <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        len <= {len[15:8], d};
                        if (len[15:8] == 8'h00 && d == 8'h00)
                            state <= S_CMD;
                        else
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        mem_addr  <= ptr;
                        mem_wdata <= d;
                        // Out-of-range bytes are consumed but never strobed.
                        if (in_range) begin
                            imem_we <= to_imem;
                            dmem_we <= !to_imem;
                        end else begin
                            err <= 1'b1;
                        end
                        ptr <= ptr + ADDR_W'(1);
                        len <= len - 16'd1;
                        if (len == 16'd1)
                            state <= S_CMD;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: directed vector table, reset/RUN sequences
// and a randomized bubbled frame against a frame-level model.
`timescale 1ns/100ps
module tb_program_loader;

    logic        clk;
    logic        rst_n;
    logic        imem_we;
    logic        dmem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        err;

    program_loader_if bus ();

    program_loader #(
        .ADDR_W    (16),
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .imem_we  (imem_we),
        .dmem_we  (dmem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] b [9];
        int         nw;
        logic       err;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int stray_cnt = 0;
    int both_cnt  = 0;
    logic acc_q = 1'b0;
    logic m_err = 1'b0;
    logic m_run = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    logic [7:0]  mon_imem [256];
    logic [7:0]  mon_dmem [256];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
    endtask

    // Write record: {7'b0, is_imem, addr[15:0], data[7:0]}.
    always @(posedge clk)
        acc_q <= bus.in_valid && bus.in_ready;

    always @(negedge clk) begin
        if (imem_we || dmem_we) begin
            obs_q.push_back({7'b0, imem_we, mem_addr, mem_wdata});
            if (imem_we && dmem_we) both_cnt++;
            if (!acc_q) stray_cnt++;
            if (imem_we) mon_imem[mem_addr[7:0]] = mem_wdata;
            else         mon_dmem[mem_addr[7:0]] = mem_wdata;
        end
    end

    // Frame-level reference: parse whole frames, emit expected writes.
    task automatic model(input logic [7:0] q [$]);
        int i;
        int a;
        int l;
        int ad;
        logic [7:0] c;
        i = 0;
        while (i < q.size() && !m_run) begin
            c = q[i];
            if (c == 8'h01 || c == 8'h02) begin
                a = {q[i+1], q[i+2]};
                l = {q[i+3], q[i+4]};
                for (int k = 0; k < l; k++) begin
                    ad = (a + k) % 65536;
                    if (ad < 256)
                        exp_q.push_back({7'b0, c == 8'h01,
                                         16'(ad), q[i+5+k]});
                    else
                        m_err = 1'b1;
                end
                i = i + 5 + l;
            end else if (c == 8'h03) begin
                m_run = 1'b1;
                i++;
            end else begin
                m_err = 1'b1;
                i++;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        chk("in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_q(input logic [7:0] q [$], input int maxgap);
        foreach (q[i]) send(q[i], maxgap);
    endtask

    task automatic flush();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic cmp_writes(input string name);
        int n;
        chk({name, "_nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({name, "_wr"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        chk({p, "_imem_we"},  {31'b0, imem_we}, 32'd0);
        chk({p, "_dmem_we"},  {31'b0, dmem_we}, 32'd0);
        chk({p, "_mem_addr"}, {16'b0, mem_addr}, 32'd0);
        chk({p, "_wdata"},    {24'b0, mem_wdata}, 32'd0);
        chk({p, "_cpu_run"},  {31'b0, cpu_run}, 32'd0);
        chk({p, "_busy"},     {31'b0, busy}, 32'd0);
        chk({p, "_err"},      {31'b0, err}, 32'd0);
    endtask

    vec_t vt [6];
    logic [7:0] q [$];
    logic [31:0] words [11];
    int base;

    initial begin
        vt[0] = '{9, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04,
                       8'h0C, 8'h00, 8'h00, 8'h05}, 4, 1'b0};
        vt[1] = '{5, '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0};
        vt[2] = '{7, '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02,
                       8'hAA, 8'hBB, 8'h00, 8'h00}, 1, 1'b1};
        vt[3] = '{1, '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b1};
        vt[4] = '{6, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                       8'h11, 8'h00, 8'h00, 8'h00}, 1, 1'b1};
        vt[5] = '{7, '{8'h02, 8'h00, 8'hFF, 8'h00, 8'h02,
                       8'hAA, 8'hBB, 8'h00, 8'h00}, 1, 1'b1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        // Write one byte so outputs are non-zero, then abort a frame.
        q = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h01, 8'h5A};
        model(q);
        send_q(q, 0);
        q = '{8'h01, 8'h00, 8'h00};
        send_q(q, 0);
        bus.in_valid = 1'b0;
        #1 chk("midframe_busy", {31'b0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #0.5 chk_reset("midrst");
        #0.5 rst_n = 1'b1;
        m_err = 1'b0;
        q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA};
        model(q);
        send_q(q, 0);
        flush();
        cmp_writes("midrst");
        chk("midrst_imem0", {24'b0, mon_imem[0]}, 32'hAA);

        foreach (vt[v]) begin
            q.delete();
            for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].b[i]);
            model(q);
            foreach (q[i]) begin
                send(q[i], 0);
                if (i == 0 && vt[v].n > 1)
                    #1 chk($sformatf("vec%0d_busy_hi", v),
                           {31'b0, busy}, 32'd1);
            end
            #1 chk($sformatf("vec%0d_busy_lo", v), {31'b0, busy}, 32'd0);
            flush();
            chk($sformatf("vec%0d_nw", v), obs_q.size(), vt[v].nw);
            cmp_writes($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_err", v), {31'b0, err}, {31'b0, vt[v].err});
            chk($sformatf("vec%0d_merr", v), {31'b0, err}, {31'b0, m_err});
        end
        chk("imem0_11", {24'b0, mon_imem[0]}, 32'h11);
        chk("dmem255_AA", {24'b0, mon_dmem[255]}, 32'hAA);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_err = 1'b0;

        // Randomized 11-instruction IMEM frame with input bubbles.
        base = 4 * int'($urandom_range(8, 53));
        q = '{8'h01, 8'h00, 8'(base), 8'h00, 8'd44};
        for (int w = 0; w < 11; w++) begin
            words[w] = $urandom;
            for (int k = 3; k >= 0; k--) q.push_back(words[w][8*k +: 8]);
        end
        model(q);
        send_q(q, 3);
        flush();
        cmp_writes("rand");
        for (int w = 0; w < 11; w++)
            chk($sformatf("rand_word%0d", w),
                {mon_imem[base+4*w], mon_imem[base+4*w+1],
                 mon_imem[base+4*w+2], mon_imem[base+4*w+3]},
                words[w]);
        chk("rand_err", {31'b0, err}, {31'b0, m_err});

        q = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h04,
              8'h00, 8'h00, 8'h00, 8'h28};
        model(q);
        send_q(q, 0);
        flush();
        cmp_writes("dmem");
        chk("dmem_word", {mon_dmem[4], mon_dmem[5], mon_dmem[6], mon_dmem[7]},
            32'd40);

        q = '{8'h03};
        model(q);
        @(negedge clk);
        chk("run_before", {31'b0, cpu_run}, 32'd0);
        send(8'h03, 0);
        #1 chk("run_after", {31'b0, cpu_run}, {31'b0, m_run});
        chk("run_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h01;
        end
        flush();
        cmp_writes("run_ignore");
        chk("run_busy", {31'b0, busy}, 32'd0);
        chk("run_hold", {31'b0, cpu_run}, 32'd1);
        chk("run_ready2", {31'b0, bus.in_ready}, 32'd0);
        chk("run_err", {31'b0, err}, {31'b0, m_err});

        chk("no_stray_we", stray_cnt, 32'd0);
        chk("no_dual_we", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
